ppu_hv_timing_gen: RTL and testbench
====================================

// Module: ppu_hv_timing_gen
// PURPOSE
// - Parametrised successor to the fixed PixelClock + HVCounters pair: the PCLK divider and H/V raster counters in one block.
// - Frame geometry is set by parameters, so 2C02 (NTSC) and 2C07 (PAL) are build-time choices with no separate source.
// - Adds what the fixed pair lacks: odd-frame dot skip, a VBlank flag with read-acknowledge race, and line/frame strobes.
// - Sits between the master clock and PPU_FSM / HVDecoder; H_out and V_out feed both directly.
// PARAMETERS
// - PCLK_DIV      4    CLK cycles per pixel clock (4 = 2C02, 5 = 2C07); must be >= 2
// - CW            9    width of the H and V counters
// - H_TOTAL       341  dots per line; H counts 0..H_TOTAL-1
// - V_TOTAL       262  lines per frame (312 for PAL); V counts 0..V_TOTAL-1
// - H_VISIBLE     256  first H value that is in horizontal blank
// - V_VISIBLE     240  first V value that is in vertical blank
// - VBL_SET_LINE  241  line on which VBL_FLAG is set
// - PRE_LINE      261  pre-render line (V_TOTAL-1 for both standards)
// - ODD_SKIP      1    1 = skip the last dot of PRE_LINE on odd frames when rendering (NTSC); 0 = never skip (PAL)
// PORTS
// - CLK          in   1   master clock
// - RES          in   1   asynchronous reset, active-high
// - REND_EN      in   1   rendering enabled (BG or OBJ); used only for the odd-frame skip
// - VBL_ACK      in   1   one-CLK pulse: status read; clears VBL_FLAG
// - PCLK_EN      out  1   one-CLK-wide pixel-clock enable
// - H_out        out  CW  horizontal counter
// - V_out        out  CW  vertical counter
// - HB           out  1   1 while H_out >= H_VISIBLE
// - VB           out  1   1 while V_out >= V_VISIBLE and V_out != PRE_LINE
// - VBL_FLAG     out  1   VBlank status flag
// - ODD          out  1   frame parity; toggles at each frame wrap
// - LINE_START   out  1   one-CLK pulse, coincident with the edge on which H_out becomes 0
// - FRAME_START  out  1   one-CLK pulse, coincident with the edge on which H_out and V_out both become 0
// BEHAVIOUR
// - Reset: all outputs are 0 and the divider is 0. Asserting RES mid-frame returns to H=0/V=0 immediately.
// - PCLK_EN is registered: divider counts 0..PCLK_DIV-1. PCLK_EN is 1 during the CLK cycle in which the divider equals PCLK_DIV-1.
//   The first PCLK_EN occurs PCLK_DIV CLK cycles after RES is released.
// - Counters, flags and strobes update only on a CLK edge where PCLK_EN==1. Latency is 1 CLK after PCLK_EN.
// - Counting: H increments. When H==H_TOTAL-1, H becomes 0 and V increments.
//   When V==V_TOTAL-1 and H wraps, V becomes 0 and ODD toggles.
// - Odd skip: if ODD_SKIP, ODD==1, REND_EN==1, V==PRE_LINE and H==H_TOTAL-2, the next step goes to H=0, V=0 and ODD toggles.
//   That frame is one dot shorter. REND_EN is sampled only at that dot.
// - VBL_FLAG is set on the step that enters (V=VBL_SET_LINE, H=1).
// - VBL_FLAG is cleared on the step that enters (V=PRE_LINE, H=1), or on any CLK where VBL_ACK==1.
// - Race: if VBL_ACK==1 on the same CLK as the set step, the clear wins and the flag stays 0 for that frame.
// - HB and VB are registered decodes of the next H/V values, so they are aligned with H_out and V_out.
// - LINE_START and FRAME_START are high for exactly one CLK. FRAME_START implies LINE_START.
// - Arithmetic is unsigned CW-bit. Wrap is by compare, never by overflow. Elaboration fails if H_TOTAL > 2**CW or V_TOTAL > 2**CW.
// STRUCTURE
// - Shared package ppu_timing_pkg: localparam sets NTSC_* (4,341,262,256,240,241,261,1) and PAL_* (5,341,312,256,240,241,311,0).
// - Sub-module ppu_pclk_div (divider + PCLK_EN register). Everything else is in this module's always blocks.
// TESTING
// - NTSC, REND_EN=0: two frames are each 341*262 = 89342 PCLK_EN pulses between FRAME_STARTs.
// - NTSC, REND_EN=1: alternating frames of 89342 / 89341 PCLK.
//   On an odd frame the step after H=339, V=261 gives H=0, V=0.
// - PAL params, REND_EN=1: every frame is 341*312 = 106392 PCLK, with 5 CLK per PCLK_EN and no skip.
// - VBL_FLAG: rises on the edge entering V=241, H=1 and falls entering V=261, H=1.
//   VBL_ACK on a mid-VBlank CLK gives 0 on the next CLK.
// - Race: VBL_ACK on the set edge -> VBL_FLAG stays 0 through V=261, and sets normally on the next frame.
// - Reset mid-frame at V=100, H=200: outputs are 0 asynchronously. First PCLK_EN comes 4 CLK after release, then H_out=1.

Source files
------------

// File: rtl/ppu_timing_pkg.sv
// ppu_timing_pkg: frame geometry presets for the 2C02 (NTSC) and 2C07 (PAL) raster timing.
package ppu_timing_pkg;

    localparam int NTSC_PCLK_DIV     = 4;
    localparam int NTSC_H_TOTAL      = 341;
    localparam int NTSC_V_TOTAL      = 262;
    localparam int NTSC_H_VISIBLE    = 256;
    localparam int NTSC_V_VISIBLE    = 240;
    localparam int NTSC_VBL_SET_LINE = 241;
    localparam int NTSC_PRE_LINE     = 261;
    localparam int NTSC_ODD_SKIP     = 1;

    localparam int PAL_PCLK_DIV      = 5;
    localparam int PAL_H_TOTAL       = 341;
    localparam int PAL_V_TOTAL       = 312;
    localparam int PAL_H_VISIBLE     = 256;
    localparam int PAL_V_VISIBLE     = 240;
    localparam int PAL_VBL_SET_LINE  = 241;
    localparam int PAL_PRE_LINE      = 311;
    localparam int PAL_ODD_SKIP      = 0;

    function automatic bit geom_fits(input int total, input int cw);
        return total <= (1 << cw);
    endfunction

endpackage

// File: rtl/ppu_pclk_div.sv
// ppu_pclk_div: divides the master clock into a one-CLK-wide registered pixel-clock enable.
module ppu_pclk_div #(
    parameter int PCLK_DIV = 4
) (
    input  logic CLK,
    input  logic RES,
    output logic PCLK_EN
);

    localparam int DW = $clog2(PCLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(PCLK_DIV - 1);

    logic [DW-1:0] div, div_nxt;

    always_comb div_nxt = (div == LAST) ? '0 : div + 1'b1;

    // The enable is a decode of the next divider value, so it is high while div == LAST.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            div     <= '0;
            PCLK_EN <= 1'b0;
        end else begin
            div     <= div_nxt;
            PCLK_EN <= (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/ppu_hv_timing_gen.sv
// ppu_hv_timing_gen: pixel-clock divider plus H/V raster counters, VBlank flag and line/frame strobes.
module ppu_hv_timing_gen
    import ppu_timing_pkg::*;
#(
    parameter int PCLK_DIV     = NTSC_PCLK_DIV,
    parameter int CW           = 9,
    parameter int H_TOTAL      = NTSC_H_TOTAL,
    parameter int V_TOTAL      = NTSC_V_TOTAL,
    parameter int H_VISIBLE    = NTSC_H_VISIBLE,
    parameter int V_VISIBLE    = NTSC_V_VISIBLE,
    parameter int VBL_SET_LINE = NTSC_VBL_SET_LINE,
    parameter int PRE_LINE     = NTSC_PRE_LINE,
    parameter int ODD_SKIP     = NTSC_ODD_SKIP
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          REND_EN,
    input  logic          VBL_ACK,
    output logic          PCLK_EN,
    output logic [CW-1:0] H_out,
    output logic [CW-1:0] V_out,
    output logic          HB,
    output logic          VB,
    output logic          VBL_FLAG,
    output logic          ODD,
    output logic          LINE_START,
    output logic          FRAME_START
);

    if (!geom_fits(H_TOTAL, CW) || !geom_fits(V_TOTAL, CW)) begin : g_bad_geom
        $error("ppu_hv_timing_gen: H_TOTAL/V_TOTAL exceed counter width");
    end
    if (PCLK_DIV < 2) begin : g_bad_div
        $error("ppu_hv_timing_gen: PCLK_DIV must be >= 2");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_SKIP = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
    localparam logic [CW-1:0] V_SET  = CW'(VBL_SET_LINE);
    localparam logic [CW-1:0] V_PRE  = CW'(PRE_LINE);
    localparam logic [CW-1:0] H_ONE  = CW'(1);

    logic          h_end, skip, line_wrap, frame_wrap, vbl_set, vbl_clr;
    logic [CW-1:0] h_nxt, v_nxt;

    ppu_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_div (
        .CLK     (CLK),
        .RES     (RES),
        .PCLK_EN (PCLK_EN)
    );

    // The odd-frame skip jumps from the second-to-last pre-render dot straight to (0,0).
    always_comb begin
        h_end      = H_out == H_LAST;
        skip       = (ODD_SKIP != 0) && ODD && REND_EN && V_out == V_PRE && H_out == H_SKIP;
        line_wrap  = skip || h_end;
        frame_wrap = skip || (h_end && V_out == V_LAST);
        h_nxt      = line_wrap ? '0 : H_out + 1'b1;
        v_nxt      = frame_wrap ? '0 : h_end ? V_out + 1'b1 : V_out;
        vbl_set    = h_nxt == H_ONE && v_nxt == V_SET;
        vbl_clr    = h_nxt == H_ONE && v_nxt == V_PRE;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            H_out       <= '0;
            V_out       <= '0;
            HB          <= 1'b0;
            VB          <= 1'b0;
            ODD         <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= PCLK_EN && line_wrap;
            FRAME_START <= PCLK_EN && frame_wrap;
            if (PCLK_EN) begin
                H_out <= h_nxt;
                V_out <= v_nxt;
                HB    <= h_nxt >= H_VIS;
                VB    <= (v_nxt >= V_VIS) && (v_nxt != V_PRE);
                ODD   <= ODD ^ frame_wrap;
            end
        end
    end

    // A status read in the same CLK as the set step wins, so that frame never shows VBlank.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES)
            VBL_FLAG <= 1'b0;
        else
            VBL_FLAG <= (VBL_ACK || (PCLK_EN && vbl_clr)) ? 1'b0 :
                        (PCLK_EN && vbl_set) ? 1'b1 : VBL_FLAG;
    end

endmodule

// File: tb/tb_ppu_hv_timing_gen.sv
// tb_ppu_hv_timing_gen: directed checks on a reduced NTSC-style raster (dut 0) and a PAL-style raster (dut 1).
module tb_ppu_hv_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       rend;
    logic       ack;
    logic       ack_b;
    logic       pe   [2];
    logic [3:0] hq   [2];
    logic [3:0] vq   [2];
    logic       hbq  [2];
    logic       vbq  [2];
    logic       vbl  [2];
    logic       odd  [2];
    logic       ls   [2];
    logic       fs   [2];
    int         total = 0;
    int         bad = 0;
    int         n, acc;

    always #5 clk = ~clk;

    // 10 dots x 8 lines, VBlank from line 5, flag set on line 6, pre-render line 7, odd skip on
    ppu_hv_timing_gen #(
        .PCLK_DIV(4), .CW(4), .H_TOTAL(10), .V_TOTAL(8), .H_VISIBLE(8), .V_VISIBLE(5),
        .VBL_SET_LINE(6), .PRE_LINE(7), .ODD_SKIP(1)
    ) u_ntsc (
        .CLK(clk), .RES(rst), .REND_EN(rend), .VBL_ACK(ack),
        .PCLK_EN(pe[0]), .H_out(hq[0]), .V_out(vq[0]), .HB(hbq[0]), .VB(vbq[0]),
        .VBL_FLAG(vbl[0]), .ODD(odd[0]), .LINE_START(ls[0]), .FRAME_START(fs[0])
    );

    // 10 dots x 16 lines fills the 4-bit V counter exactly; no odd skip
    ppu_hv_timing_gen #(
        .PCLK_DIV(5), .CW(4), .H_TOTAL(10), .V_TOTAL(16), .H_VISIBLE(8), .V_VISIBLE(12),
        .VBL_SET_LINE(13), .PRE_LINE(15), .ODD_SKIP(0)
    ) u_pal (
        .CLK(clk), .RES(rst), .REND_EN(rend), .VBL_ACK(ack_b),
        .PCLK_EN(pe[1]), .H_out(hq[1]), .V_out(vq[1]), .HB(hbq[1]), .VB(vbq[1]),
        .VBL_FLAG(vbl[1]), .ODD(odd[1]), .LINE_START(ls[1]), .FRAME_START(fs[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pe(input int s);
        int k = 0;
        while (pe[s] !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        if (pe[s] !== 1'b1) chk("pclk_timeout", 0, 1);
    endtask

    task automatic adv(input int s);
        wait_pe(s);
        tick();
    endtask

    task automatic adv_to(input int s, input int h, input int v, output int cnt);
        cnt = 0;
        do begin
            adv(s);
            cnt++;
        end while (!(hq[s] == 4'(h) && vq[s] == 4'(v)) && cnt < 400);
        chk("reach_hv", {hq[s], vq[s]}, {4'(h), 4'(v)});
    endtask

    task automatic frame_len(input int s, output int cnt);
        cnt = 0;
        do begin
            adv(s);
            cnt++;
        end while (fs[s] !== 1'b1 && cnt < 400);
    endtask

    task automatic chk_zero(input string tag);
        for (int s = 0; s < 2; s++)
            chk(tag, {pe[s], hq[s], vq[s], hbq[s], vbq[s], vbl[s], odd[s], ls[s], fs[s]}, 0);
    endtask

    task automatic release_reset(input string tag);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk({tag, "_pe_early"}, pe[0], 0);
        tick();
        chk({tag, "_pe_first"}, pe[0], 1);
        chk({tag, "_h_before"}, hq[0], 0);
        tick();
        chk({tag, "_h_after"}, hq[0], 1);
        chk({tag, "_pe_width"}, pe[0], 0);
        chk({tag, "_pal_pe_first"}, pe[1], 1);
        tick();
        chk({tag, "_pal_h_after"}, hq[1], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        rend  = 1'b0;
        ack   = 1'b0;
        ack_b = 1'b0;
        tick();
        chk_zero("reset_outs");
        release_reset("rel0");
        adv_to(0, 7, 0, n);
        chk("hb_visible", hbq[0], 0);
        adv(0);
        chk("hb_blank", hbq[0], 1);
        chk("vb_line0", vbq[0], 0);
        adv(0);
        adv(0);
        chk("line_wrap_hv", {hq[0], vq[0]}, {4'd0, 4'd1});
        chk("line_start", ls[0], 1);
        chk("line_no_frame", fs[0], 0);
        chk("hb_wrap", hbq[0], 0);
        tick();
        chk("line_start_width", ls[0], 0);
        adv_to(0, 0, 6, n);
        chk("vbl_before_set", vbl[0], 0);
        chk("vb_line6", vbq[0], 1);
        adv(0);
        chk("vbl_set", vbl[0], 1);
        adv_to(0, 5, 6, n);
        chk("vbl_held", vbl[0], 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("vbl_ack_clear", vbl[0], 0);
        adv_to(0, 0, 0, n);
        chk("frame_start", fs[0], 1);
        chk("frame_implies_line", ls[0], 1);
        chk("odd_toggle1", odd[0], 1);
        chk("vb_frame0", vbq[0], 0);
        tick();
        chk("frame_start_width", fs[0], 0);
        frame_len(0, n);
        chk("len_odd_norend", n, 80);
        chk("odd_toggle2", odd[0], 0);
        rend = 1'b1;
        adv_to(0, 1, 6, n);
        acc = n;
        chk("vbl_set_f2", vbl[0], 1);
        adv_to(0, 0, 7, n);
        acc += n;
        chk("vbl_kept_pre", vbl[0], 1);
        chk("vb_pre_line", vbq[0], 0);
        adv(0);
        acc++;
        chk("vbl_clr_pre", vbl[0], 0);
        frame_len(0, n);
        chk("len_even_rend", acc + n, 80);
        chk("odd_toggle3", odd[0], 1);
        adv_to(0, 8, 7, n);
        adv(0);
        chk("skip_hv", {hq[0], vq[0]}, {4'd0, 4'd0});
        chk("skip_frame_start", fs[0], 1);
        chk("len_odd_skip", n + 1, 79);
        chk("odd_toggle4", odd[0], 0);
        adv_to(0, 0, 6, n);
        wait_pe(0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("race_hv", {hq[0], vq[0]}, {4'd1, 4'd6});
        chk("race_vbl", vbl[0], 0);
        adv_to(0, 0, 7, n);
        chk("race_vbl_pre", vbl[0], 0);
        frame_len(0, n);
        adv_to(0, 1, 6, n);
        chk("race_next_frame", vbl[0], 1);
        adv_to(0, 4, 3, n);
        rst = 1'b1;
        #1;
        chk_zero("midframe_reset");
        release_reset("rel1");
        chk("odd_after_reset", odd[0], 0);
        wait_pe(0);
        n = 0;
        do begin
            tick();
            n++;
        end while (pe[0] !== 1'b1 && n < 12);
        chk("ntsc_pclk_period", n, 4);
        wait_pe(1);
        n = 0;
        do begin
            tick();
            n++;
        end while (pe[1] !== 1'b1 && n < 12);
        chk("pal_pclk_period", n, 5);
        adv_to(1, 0, 12, n);
        chk("pal_vb_line12", vbq[1], 1);
        adv_to(1, 9, 15, n);
        chk("pal_hb_end", hbq[1], 1);
        chk("pal_vb_pre", vbq[1], 0);
        adv(1);
        chk("pal_wrap_hv", {hq[1], vq[1]}, {4'd0, 4'd0});
        chk("pal_frame_start", fs[1], 1);
        chk("pal_odd1", odd[1], 1);
        frame_len(1, n);
        chk("pal_len_odd", n, 160);
        chk("pal_odd2", odd[1], 0);
        frame_len(1, n);
        chk("pal_len_even", n, 160);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
